if_delay_slot_sequencer: RTL and testbench
==========================================

# if_delay_slot_sequencer

Fetch-PC sequencer for the IF stage. It owns the fetch PC register and turns the per-group branch prediction (target, delay-slot-needed, delay-slot-already-fetched, fifth-instruction address) into a legal MIPS fetch order. When a predicted-taken branch's delay slot lies outside the current fetch group, the block inserts a delay-slot-only fetch and then redirects to the saved target. It sits between the delay-slot/branch predictors and the instruction-cache request port. Backend flushes override everything.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: fetch PC loaded at reset.
- `GROUP_BYTES`, default 16: fetch-group size in bytes (4 instructions). Must be a power of two.
- `clk` input 1: clock.
- `resetn` input 1: synchronous, active-low reset.
- `fetch_ready_i` input 1: the I-cache accepts `pc_o` this cycle. Accept = `pc_valid_o && fetch_ready_i`.
- `pred_taken_i` input 1: the group being accepted holds a predicted-taken branch.
- `pred_target_i` input 32: predicted branch target.
- `pred_need_ds_i` input 1: the taken branch has a delay slot.
- `pred_ds_getted_i` input 1: the delay slot lies inside the current group.
- `ds_addr_i` input 32: address of the first instruction after the current group (the delay slot).
- `flush_i` input 1: backend redirect (exception, eret, mispredict).
- `flush_pc_i` input 32: redirect address.
- `pc_o` output 32: current fetch PC.
- `pc_valid_o` output 1: `pc_o` is a valid request.
- `ds_only_o` output 1: the group at `pc_o` is a delay-slot fetch. Downstream keeps only slot 0.
- `ds_split_cnt_o` output 32: saturating count of inserted delay-slot fetches.

## Operation
- FSM states:
  - IDLE: normal fetch.
  - DS_WAIT: `pc_o` holds the delay-slot address and `target_q` holds the pending target.
- Sequential PC: `seq_pc = {pc_o[31:log2(GROUP_BYTES)] + 1, zeros}`. Drop the carry out of bit 31 (wrap to 0).
- Priority per cycle: reset > `flush_i` > accept > hold.
- Flush (any state, with or without accept):
  - `pc_o <= flush_pc_i`
  - state → IDLE
  - `target_q <= 0`
  - `ds_only_o <= 0`
  - `pc_valid_o <= 1`
- Accept in IDLE:
  - `!pred_taken_i`: `pc_o <= seq_pc`.
  - `pred_taken_i && (!pred_need_ds_i || pred_ds_getted_i)`: `pc_o <= pred_target_i`.
  - `pred_taken_i && pred_need_ds_i && !pred_ds_getted_i`:
    - `pc_o <= ds_addr_i`
    - `target_q <= pred_target_i`
    - `ds_only_o <= 1`
    - state → DS_WAIT
    - increment `ds_split_cnt_o`, saturating at 32'hFFFF_FFFF.
- Accept in DS_WAIT:
  - All `pred_*` inputs are ignored. A delay slot cannot itself redirect.
  - `pc_o <= target_q`, `ds_only_o <= 0`, state → IDLE.
- No accept: every register holds, and the prediction inputs are don't-care.
- `ds_only_o` is a registered copy of `state == DS_WAIT`.

## Timing
- Reset values (asserted at the edge where `resetn == 0`):
  - `pc_o = RESET_PC`
  - `pc_valid_o = 0`
  - `ds_only_o = 0`
  - `ds_split_cnt_o = 0`
  - state = IDLE
  - `target_q = 0`
- `pc_valid_o` rises one cycle after `resetn` deasserts and then stays 1.
- Reset asserted mid-DS_WAIT discards the pending target.
- All outputs are registered. A new PC is visible on the cycle after the accept or flush edge, so latency is 1.
- Back-to-back accepts: one group per cycle. A split costs exactly one extra fetch cycle.
- Stall in DS_WAIT for N cycles: `pc_o` and `target_q` hold, and the redirect to the target happens on the first accept.
- Flush and accept in the same cycle: the flush wins and the prediction is discarded. The counter does not increment.
- No combinational path from any input to any output.

## Structure
- Shared package (`MyDefines.v`) holds:
  - the `SINGLE_WORD` range
  - the `RESET_PC` default
  - the state encodings `DSS_IDLE = 1'b0` and `DSS_WAIT = 1'b1`
  - `GROUP_BYTES`
- One natural sub-module, `sat_counter32`: a 32-bit saturating incrementer with `clk`, `resetn` and `inc_i`. Reusable by other IF performance counters.
- Everything else stays flat, roughly 150 lines.

## Test plan
- **Reset:** hold `resetn = 0` for 3 cycles, then release.
  - `pc_o = BFC0_0000` and `pc_valid_o = 0` during reset.
  - `pc_valid_o = 1` one cycle after release.
  - `ds_split_cnt_o = 0`.
- **Sequential fetch and wrap:** accept with `pred_taken_i = 0` from `BFC0_0008`, then force `pc_o` near the top via a flush to `FFFF_FFF0`.
  - `BFC0_0008` → `BFC0_0010`.
  - A flush to `FFFF_FFF0` followed by an accept → `0000_0000`.
- **In-group delay slot:** taken, `need_ds = 1`, `ds_getted = 1`, target `8000_1000`.
  - Next `pc_o = 8000_1000`, `ds_only_o = 0`, counter unchanged.
- **Split:** taken, `need_ds = 1`, `ds_getted = 0`, `ds_addr = BFC0_0010`, target `8000_2000`, then hold `fetch_ready_i = 0` for 2 cycles.
  - `pc_o = BFC0_0010` and `ds_only_o = 1` for 3 cycles.
  - `pred_taken_i = 1` driven during DS_WAIT is ignored.
  - After the next accept: `pc_o = 8000_2000`, `ds_only_o = 0`, counter = 1.
- **Flush in DS_WAIT with simultaneous accept:** `flush_pc = BFC0_0380`.
  - `pc_o = BFC0_0380`, state IDLE, `ds_only_o = 0`.
  - The next accept gives `BFC0_0390`, not the old target.
- **Counter saturation:** preload the count to `FFFF_FFFE`, then perform 3 splits.
  - The count reads `FFFF_FFFF` and stays there.

Source files
------------

// File: rtl/if_delay_slot_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_delay_slot_sequencer_pkg
// Description : Shared definitions for the IF-stage fetch-PC sequencer:
//               word range, reset PC, fetch-group size, FSM state encodings
//               and the next-group address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package if_delay_slot_sequencer_pkg;

  // Architectural word range
  localparam int SINGLE_WORD_MSB = 31;
  localparam int SINGLE_WORD_LSB = 0;
  typedef logic [SINGLE_WORD_MSB:SINGLE_WORD_LSB] word_t;

  // Boot vector and fetch-group size defaults
  localparam word_t       RESET_PC_DEFAULT    = 32'hBFC0_0000;
  localparam int unsigned GROUP_BYTES_DEFAULT = 16;

  // Sequencer states
  typedef enum logic [0:0] {
    DSS_IDLE = 1'b0,
    DSS_WAIT = 1'b1
  } dss_state_t;

  // Address of the next fetch group; the carry out of bit 31 is dropped
  function automatic word_t nextGroupPc(input word_t pc, input int unsigned offBits);
    word_t w_grp;
    w_grp = (pc >> offBits) + 32'd1;
    return w_grp << offBits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_delay_slot_sequencer_sat_counter32.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter32
// Description : 32-bit saturating event counter. Counts inc_i pulses and
//               sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter32 #(
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] r_count;

  // Increment on request unless already saturated
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count <= INIT_VALUE;
    end else if (inc_i && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/if_delay_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : if_delay_slot_sequencer
// Description : IF-stage fetch-PC sequencer. Owns the fetch PC and turns the
//               per-group branch prediction into a legal MIPS fetch order,
//               inserting a delay-slot-only fetch when a taken branch's delay
//               slot lies beyond the current group. Backend flush overrides.
// Revision    : 1.0 - initial release
// ============================================================================
module if_delay_slot_sequencer
  import if_delay_slot_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int unsigned GROUP_BYTES    = GROUP_BYTES_DEFAULT,
  parameter logic [31:0] SPLIT_CNT_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fetch_ready_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  input  logic        pred_need_ds_i,
  input  logic        pred_ds_getted_i,
  input  logic [31:0] ds_addr_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        ds_only_o,
  output logic [31:0] ds_split_cnt_o
);

  localparam int unsigned c_GROUP_OFF_BITS = $clog2(GROUP_BYTES);

  dss_state_t  r_state;
  dss_state_t  w_stateNext;
  logic [31:0] r_pc;
  logic [31:0] w_pcNext;
  logic [31:0] r_targetQ;
  logic [31:0] w_targetNext;
  logic        r_valid;
  logic        r_dsOnly;
  logic        w_accept;
  logic        w_splitInc;
  logic [31:0] w_seqPc;

  assign w_accept = r_valid && fetch_ready_i;
  assign w_seqPc  = nextGroupPc(r_pc, c_GROUP_OFF_BITS);

  // State, PC and pending-target registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= DSS_IDLE;
      r_pc      <= RESET_PC;
      r_targetQ <= 32'h0000_0000;
      r_valid   <= 1'b0;
      r_dsOnly  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_targetQ <= w_targetNext;
      r_valid   <= 1'b1;
      r_dsOnly  <= (w_stateNext == DSS_WAIT);
    end
  end

  // Next-state and next-PC selection: flush beats accept beats hold
  always_comb begin
    w_stateNext  = r_state;
    w_pcNext     = r_pc;
    w_targetNext = r_targetQ;
    w_splitInc   = 1'b0;
    if (flush_i) begin
      w_stateNext  = DSS_IDLE;
      w_pcNext     = flush_pc_i;
      w_targetNext = 32'h0000_0000;
    end else if (w_accept) begin
      case (r_state)
        DSS_IDLE: begin
          if (!pred_taken_i) begin
            w_pcNext = w_seqPc;
          end else if (!pred_need_ds_i || pred_ds_getted_i) begin
            w_pcNext = pred_target_i;
          end else begin
            // Delay slot is outside this group: fetch it alone first
            w_pcNext     = ds_addr_i;
            w_targetNext = pred_target_i;
            w_stateNext  = DSS_WAIT;
            w_splitInc   = 1'b1;
          end
        end
        DSS_WAIT: begin
          // A delay slot never redirects; prediction inputs are ignored
          w_pcNext    = r_targetQ;
          w_stateNext = DSS_IDLE;
        end
        default: begin
          w_stateNext = DSS_IDLE;
        end
      endcase
    end
  end

  sat_counter32 #(
    .INIT_VALUE (SPLIT_CNT_INIT)
  ) uSplitCnt (
    .clk     (clk),
    .resetn  (resetn),
    .inc_i   (w_splitInc),
    .count_o (ds_split_cnt_o)
  );

  assign pc_o       = r_pc;
  assign pc_valid_o = r_valid;
  assign ds_only_o  = r_dsOnly;

endmodule
`default_nettype wire

// File: tb/tb_if_delay_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_delay_slot_sequencer
// Description : Self-checking bench for if_delay_slot_sequencer: directed
//               scenarios followed by randomized traffic against a
//               behavioural fetch-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_delay_slot_sequencer;

  localparam longint GB = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_ready_i;
  logic        pred_taken_i;
  logic [31:0] pred_target_i;
  logic        pred_need_ds_i;
  logic        pred_ds_getted_i;
  logic [31:0] ds_addr_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        ds_only_o;
  logic [31:0] ds_split_cnt_o;
  // second instance whose counter starts near saturation
  logic [31:0] satPc;
  logic        satValid;
  logic        satDsOnly;
  logic [31:0] satCnt;

  int nChecks = 0;
  int nErrors = 0;

  // reference model: architectural fetch order
  logic [31:0] mPc;
  logic        mValid;
  logic        mInDsFetch;
  logic [31:0] mPendingTarget;
  longint      mSplits;

  always #5 clk = ~clk;

  if_delay_slot_sequencer dut (
    .clk              (clk),
    .resetn           (resetn),
    .fetch_ready_i    (fetch_ready_i),
    .pred_taken_i     (pred_taken_i),
    .pred_target_i    (pred_target_i),
    .pred_need_ds_i   (pred_need_ds_i),
    .pred_ds_getted_i (pred_ds_getted_i),
    .ds_addr_i        (ds_addr_i),
    .flush_i          (flush_i),
    .flush_pc_i       (flush_pc_i),
    .pc_o             (pc_o),
    .pc_valid_o       (pc_valid_o),
    .ds_only_o        (ds_only_o),
    .ds_split_cnt_o   (ds_split_cnt_o)
  );

  if_delay_slot_sequencer #(
    .SPLIT_CNT_INIT (32'hFFFF_FFFE)
  ) dutSat (
    .clk              (clk),
    .resetn           (resetn),
    .fetch_ready_i    (fetch_ready_i),
    .pred_taken_i     (pred_taken_i),
    .pred_target_i    (pred_target_i),
    .pred_need_ds_i   (pred_need_ds_i),
    .pred_ds_getted_i (pred_ds_getted_i),
    .ds_addr_i        (ds_addr_i),
    .flush_i          (flush_i),
    .flush_pc_i       (flush_pc_i),
    .pc_o             (satPc),
    .pc_valid_o       (satValid),
    .ds_only_o        (satDsOnly),
    .ds_split_cnt_o   (satCnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] satAdd(input longint base, input longint n);
    longint s;
    s = base + n;
    if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
    return s[31:0];
  endfunction

  // Advance the reference model by one clock using the inputs seen at the edge
  task automatic modelStep();
    if (!resetn) begin
      mPc = 32'hBFC0_0000; mValid = 1'b0; mInDsFetch = 1'b0;
      mPendingTarget = 32'h0; mSplits = 0;
    end else if (flush_i) begin
      mPc = flush_pc_i; mValid = 1'b1; mInDsFetch = 1'b0; mPendingTarget = 32'h0;
    end else begin
      if (mValid && fetch_ready_i) begin
        if (mInDsFetch) begin
          mPc = mPendingTarget; mInDsFetch = 1'b0;
        end else if (!pred_taken_i) begin
          mPc = 32'((longint'(mPc) / GB + 1) * GB);
        end else if (pred_need_ds_i && !pred_ds_getted_i) begin
          mPendingTarget = pred_target_i; mPc = ds_addr_i;
          mInDsFetch = 1'b1; mSplits++;
        end else begin
          mPc = pred_target_i;
        end
      end
      mValid = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic setPred(input logic taken, input logic need, input logic getted,
                         input logic [31:0] tgt, input logic [31:0] dsa);
    pred_taken_i = taken; pred_need_ds_i = need; pred_ds_getted_i = getted;
    pred_target_i = tgt; ds_addr_i = dsa;
  endtask

  initial begin
    resetn = 1'b0; fetch_ready_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
    setPred(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mPc = 32'h0; mValid = 1'b0; mInDsFetch = 1'b0; mPendingTarget = 32'h0; mSplits = 0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      fetch_ready_i = 1'b1;
      tick();
      chk("rst_pc", pc_o, 32'hBFC0_0000);
      chk("rst_valid", {31'b0, pc_valid_o}, 32'd0);
      chk("rst_ds_only", {31'b0, ds_only_o}, 32'd0);
      chk("rst_cnt", ds_split_cnt_o, 32'd0);
    end
    resetn = 1'b1;
    tick();
    chk("valid_after_rst", {31'b0, pc_valid_o}, 32'd1);
    chk("pc_after_rst", pc_o, 32'hBFC0_0000);

    // Sequential fetch and wrap
    flush_i = 1'b1; flush_pc_i = 32'hBFC0_0008;
    tick();
    chk("flush_pc", pc_o, 32'hBFC0_0008);
    flush_i = 1'b0;
    tick();
    chk("seq_pc", pc_o, 32'hBFC0_0010);
    flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFF0;
    tick();
    flush_i = 1'b0;
    tick();
    chk("seq_wrap", pc_o, 32'h0000_0000);

    // Taken branch with the delay slot inside the group
    setPred(1'b1, 1'b1, 1'b1, 32'h8000_1000, 32'h0000_0010);
    tick();
    chk("ingroup_pc", pc_o, 32'h8000_1000);
    chk("ingroup_ds_only", {31'b0, ds_only_o}, 32'd0);
    chk("ingroup_cnt", ds_split_cnt_o, 32'd0);

    // Split with a two-cycle stall in the delay-slot fetch
    setPred(1'b1, 1'b1, 1'b0, 32'h8000_2000, 32'hBFC0_0010);
    tick();
    chk("split_pc", pc_o, 32'hBFC0_0010);
    chk("split_ds_only", {31'b0, ds_only_o}, 32'd1);
    fetch_ready_i = 1'b0;
    setPred(1'b1, 1'b0, 1'b0, 32'h1234_5670, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_pc", pc_o, 32'hBFC0_0010);
      chk("stall_ds_only", {31'b0, ds_only_o}, 32'd1);
    end
    fetch_ready_i = 1'b1;
    setPred(1'b1, 1'b1, 1'b0, 32'h0000_9990, 32'h0000_4440);
    tick();
    chk("redirect_pc", pc_o, 32'h8000_2000);
    chk("redirect_ds_only", {31'b0, ds_only_o}, 32'd0);
    chk("redirect_cnt", ds_split_cnt_o, 32'd1);

    // Flush during the delay-slot fetch, together with an accept
    setPred(1'b1, 1'b1, 1'b0, 32'h8000_3000, 32'h8000_2010);
    tick();
    chk("split2_ds_only", {31'b0, ds_only_o}, 32'd1);
    flush_i = 1'b1; flush_pc_i = 32'hBFC0_0380;
    tick();
    chk("flushwait_pc", pc_o, 32'hBFC0_0380);
    chk("flushwait_ds_only", {31'b0, ds_only_o}, 32'd0);
    chk("flushwait_cnt", ds_split_cnt_o, 32'd2);
    flush_i = 1'b0;
    setPred(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("after_flush_seq", pc_o, 32'hBFC0_0390);

    // Counter saturation on the preloaded instance
    resetn = 1'b0;
    tick();
    chk("sat_rst_cnt", satCnt, 32'hFFFF_FFFE);
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      setPred(1'b1, 1'b1, 1'b0, 32'h8000_4000 + 32'(i * 16), 32'hBFC0_0020);
      tick();
      chk("sat_cnt", satCnt, 32'hFFFF_FFFF);
      chk("main_cnt", ds_split_cnt_o, 32'(i + 1));
      setPred(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
    end

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      resetn        = ($urandom_range(0, 79) != 0);
      flush_i       = ($urandom_range(0, 15) == 0);
      flush_pc_i    = $urandom() & 32'hFFFF_FFFC;
      fetch_ready_i = ($urandom_range(0, 3) != 0);
      setPred(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFF0);
      tick();
      chk("rnd_pc", pc_o, mPc);
      chk("rnd_valid", {31'b0, pc_valid_o}, {31'b0, mValid});
      chk("rnd_ds_only", {31'b0, ds_only_o}, {31'b0, mInDsFetch});
      chk("rnd_cnt", ds_split_cnt_o, satAdd(0, mSplits));
      chk("rnd_sat_cnt", satCnt, satAdd(64'h0000_0000_FFFF_FFFE, mSplits));
      chk("rnd_sat_pc", satPc, mPc);
      chk("rnd_sat_ds_only", {31'b0, satDsOnly}, {31'b0, mInDsFetch});
      chk("rnd_sat_valid", {31'b0, satValid}, {31'b0, mValid});
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
